// File: rtl/beatmap_sequencer.sv
// beatmap_sequencer
//   Steps through the beatmap notes ROM one row per beat and offers every
//   non-empty 4-lane row to the lane spawner over a valid/ready handshake.
//   It owns the beat timebase, the ROM address and end-of-song detection.
//
// Ports
//   clk          system clock, posedge
//   resetn       asynchronous active-low reset
//   start        1-cycle pulse, begins the song at row 0 (ignored while busy)
//   pause        level, freezes the beat counter
//   rom_address  registered row index to the notes ROM
//   rom_data     ROM row, valid one cycle after the address is sampled
//   note_valid   note_lanes holds a row for the spawner
//   note_lanes   bit i = spawn a note in lane i
//   note_ready   spawner accepts the row when note_valid & note_ready
//   busy         song in progress
//   done         song finished, held until the next start
//   overrun      sticky, a beat was dropped; cleared by start
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start after reset
// WAIT_BEAT | waiting for a beat tick (or a remembered pending beat)
// FETCH     | rom_address stable, ROM samples it at the end of the cycle
// CAPTURE   | rom_data valid; load the row or skip an empty one
// PRESENT   | note_valid high, waiting for note_ready
// DONE      | last row handled, waiting for start
module beatmap_sequencer #(
  parameter int CLKS_PER_BEAT = 12_500_000,
  parameter int NUM_ROWS      = 17,
  parameter int ADDR_W        = 13,
  parameter int LANES         = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [LANES-1:0]  rom_data,
  output logic              note_valid,
  output logic [LANES-1:0]  note_lanes,
  input  logic              note_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BEAT);
  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(CLKS_PER_BEAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_BEAT, FETCH, CAPTURE, PRESENT, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic             pending;
  logic             running;
  logic             tick;
  logic             last_row;

  assign running  = (state == WAIT_BEAT) || (state == FETCH) ||
                    (state == CAPTURE)   || (state == PRESENT);
  assign tick     = running && (beat_cnt == BEAT_LAST) && !pause;
  assign last_row = (rom_address == LAST_ROW);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      pending     <= 1'b0;
      rom_address <= '0;
      note_valid  <= 1'b0;
      note_lanes  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (running && !pause)
        beat_cnt <= tick ? '0 : beat_cnt + 1'b1;

      // A beat arriving while a row is in flight is remembered once;
      // a second one before it is served is lost.
      if (tick && (state != WAIT_BEAT)) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= WAIT_BEAT;
            rom_address <= '0;
            beat_cnt    <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
          end
        end

        WAIT_BEAT: begin
          // tick together with pending consumes one of them; pending stays set
          if (tick || pending) begin
            state <= FETCH;
            if (!tick) pending <= 1'b0;
          end
        end

        FETCH: state <= CAPTURE;

        CAPTURE: begin
          if (rom_data != '0) begin
            note_lanes <= rom_data;
            note_valid <= 1'b1;
            state      <= PRESENT;
          end else if (last_row) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            rom_address <= rom_address + 1'b1;
            state       <= WAIT_BEAT;
          end
        end

        PRESENT: begin
          if (note_ready) begin
            note_valid <= 1'b0;
            if (last_row) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              rom_address <= rom_address + 1'b1;
              state       <= WAIT_BEAT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
